// File: rtl/alu_seq_muldiv_pkg.sv
// Shared datapath constants for the multi-cycle MIPS ALU: opcode encodings.
package alu_seq_muldiv_pkg;

    localparam int unsigned ALU_OP_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADDU_OP  = 5'h00;
    localparam logic [ALU_OP_W-1:0] ALU_SUBU_OP  = 5'h01;
    localparam logic [ALU_OP_W-1:0] ALU_ADD_OP   = 5'h02;
    localparam logic [ALU_OP_W-1:0] ALU_SUB_OP   = 5'h03;
    localparam logic [ALU_OP_W-1:0] ALU_AND_OP   = 5'h04;
    localparam logic [ALU_OP_W-1:0] ALU_OR_OP    = 5'h05;
    localparam logic [ALU_OP_W-1:0] ALU_XOR_OP   = 5'h06;
    localparam logic [ALU_OP_W-1:0] ALU_NOR_OP   = 5'h07;
    localparam logic [ALU_OP_W-1:0] ALU_SLT_OP   = 5'h08;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU_OP  = 5'h09;
    localparam logic [ALU_OP_W-1:0] ALU_LUI_OP   = 5'h0A;
    localparam logic [ALU_OP_W-1:0] ALU_SLL_OP   = 5'h0B;
    localparam logic [ALU_OP_W-1:0] ALU_SRL_OP   = 5'h0C;
    localparam logic [ALU_OP_W-1:0] ALU_SRA_OP   = 5'h0D;
    localparam logic [ALU_OP_W-1:0] ALU_SLLV_OP  = 5'h0E;
    localparam logic [ALU_OP_W-1:0] ALU_SRLV_OP  = 5'h0F;
    localparam logic [ALU_OP_W-1:0] ALU_SRAV_OP  = 5'h10;
    localparam logic [ALU_OP_W-1:0] ALU_MULT_OP  = 5'h11;
    localparam logic [ALU_OP_W-1:0] ALU_MULTU_OP = 5'h12;
    localparam logic [ALU_OP_W-1:0] ALU_DIV_OP   = 5'h13;
    localparam logic [ALU_OP_W-1:0] ALU_DIVU_OP  = 5'h14;
    localparam logic [ALU_OP_W-1:0] ALU_MFHI_OP  = 5'h15;
    localparam logic [ALU_OP_W-1:0] ALU_MFLO_OP  = 5'h16;
    localparam logic [ALU_OP_W-1:0] ALU_MTHI_OP  = 5'h17;
    localparam logic [ALU_OP_W-1:0] ALU_MTLO_OP  = 5'h18;

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative 1-bit/cycle shift-add multiplier and restoring divider on magnitudes;
// signs are stripped at load and reapplied to the final iteration's result.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic             run_q, div_q, neg_quo_q, neg_rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, sh_q, m_q;
    logic [WIDTH-1:0] acc_d, sh_d;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   add_sum, trial, sub_diff;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    // acc holds the product high half / partial remainder; sh holds multiplier / quotient bits
    assign add_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : '0);
    assign trial    = {acc_q, sh_q[WIDTH-1]};
    assign sub_diff = trial - {1'b0, m_q};

    always_comb begin
        if (div_q) begin
            if (sub_diff[WIDTH]) begin
                acc_d = trial[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = sub_diff[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_d = add_sum[WIDTH:1];
            sh_d  = {add_sum[0], sh_q[WIDTH-1:1]};
        end
    end

    assign prod     = {acc_d, sh_d};
    assign prod_neg = -prod;

    always_comb begin
        if (div_q) begin
            hi = neg_rem_q ? -acc_d : acc_d;
            lo = neg_quo_q ? -sh_d : sh_d;
        end else if (neg_quo_q) begin
            {hi, lo} = prod_neg;
        end else begin
            {hi, lo} = prod;
        end
    end

    assign fin  = run_q && (cnt_q == CNT_W'(1));
    assign busy = run_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= 1'b0;
            div_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            m_q       <= '0;
        end else if (go) begin
            run_q     <= 1'b1;
            div_q     <= is_div;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= CNT_W'(WIDTH);
            acc_q     <= '0;
            sh_q      <= a_abs;
            m_q       <= b_abs;
        end else if (run_q) begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (fin) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Multi-cycle ALU: single-cycle integer/shift/compare ops plus iterative MULT/DIV into HI/LO.
module alu_seq_muldiv
    import alu_seq_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 5,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   res,
    output logic               zf,
    output logic               ovf,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e state_q, state_d;

    logic               accept, go, is_md, is_div, is_signed, div_zero;
    logic               md_busy, md_fin;
    logic [WIDTH-1:0]   md_hi, md_lo;
    logic [WIDTH-1:0]   sc_res, sc_hi, sc_lo;
    logic               sc_ovf;
    logic [WIDTH-1:0]   sum, diff;
    logic [SHAMT_W-1:0] vamt;
    logic [WIDTH-1:0]   res_q, hi_q, lo_q;
    logic               zf_q, ovf_q, done_q, zf_pend_q;

    assign accept   = start & ~busy;
    assign div_zero = is_div & (b == '0);
    assign sum      = a + b;
    assign diff     = a - b;
    assign vamt     = a[SHAMT_W-1:0];

    always_comb begin
        is_md     = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        case (op)
            OP_W'(ALU_MULT_OP):  begin is_md = 1'b1; is_signed = 1'b1; end
            OP_W'(ALU_MULTU_OP): begin is_md = 1'b1; end
            OP_W'(ALU_DIV_OP):   begin is_md = 1'b1; is_div = 1'b1; is_signed = 1'b1; end
            OP_W'(ALU_DIVU_OP):  begin is_md = 1'b1; is_div = 1'b1; end
            default: ;
        endcase
    end

    // One-cycle results; DIV/DIVU only land here on the divide-by-zero early exit
    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_hi  = hi_q;
        sc_lo  = lo_q;
        case (op)
            OP_W'(ALU_ADDU_OP): sc_res = sum;
            OP_W'(ALU_SUBU_OP): sc_res = diff;
            OP_W'(ALU_ADD_OP): begin
                sc_res = sum;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_W'(ALU_SUB_OP): begin
                sc_res = diff;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_W'(ALU_AND_OP):  sc_res = a & b;
            OP_W'(ALU_OR_OP):   sc_res = a | b;
            OP_W'(ALU_XOR_OP):  sc_res = a ^ b;
            OP_W'(ALU_NOR_OP):  sc_res = ~(a | b);
            OP_W'(ALU_SLT_OP):  sc_res = WIDTH'($signed(a) < $signed(b));
            OP_W'(ALU_SLTU_OP): sc_res = WIDTH'(a < b);
            OP_W'(ALU_LUI_OP):  sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_W'(ALU_SLL_OP):  sc_res = b << shamt;
            OP_W'(ALU_SRL_OP):  sc_res = b >> shamt;
            OP_W'(ALU_SRA_OP):  sc_res = $signed(b) >>> shamt;
            OP_W'(ALU_SLLV_OP): sc_res = b << vamt;
            OP_W'(ALU_SRLV_OP): sc_res = b >> vamt;
            OP_W'(ALU_SRAV_OP): sc_res = $signed(b) >>> vamt;
            OP_W'(ALU_DIV_OP), OP_W'(ALU_DIVU_OP): begin
                sc_res = '1;
                sc_lo  = '1;
                sc_hi  = a;
            end
            OP_W'(ALU_MFHI_OP): sc_res = hi_q;
            OP_W'(ALU_MFLO_OP): sc_res = lo_q;
            OP_W'(ALU_MTHI_OP): begin sc_res = a; sc_hi = a; end
            OP_W'(ALU_MTLO_OP): begin sc_res = a; sc_lo = a; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && is_md && !div_zero) state_d = StExec;
            StExec:  if (md_fin) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StExec) | md_busy;
        go   = accept & is_md & ~div_zero;
    end

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .is_div   (is_div),
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .busy     (md_busy),
        .fin      (md_fin),
        .hi       (md_hi),
        .lo       (md_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            zf_q      <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            zf_pend_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (go) begin
                zf_pend_q <= (a == b);
            end else if (accept) begin
                res_q  <= sc_res;
                hi_q   <= sc_hi;
                lo_q   <= sc_lo;
                zf_q   <= (a == b);
                ovf_q  <= sc_ovf;
                done_q <= 1'b1;
            end
            if (md_fin) begin
                res_q  <= md_lo;
                hi_q   <= md_hi;
                lo_q   <= md_lo;
                zf_q   <= zf_pend_q;
                ovf_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done = done_q;
    assign res  = res_q;
    assign zf   = zf_q;
    assign ovf  = ovf_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
